// File: rtl/sprite_fetch.sv
// sprite_fetch: turns a (kind, x, y) tile-pixel request into a sprite-sheet
// ROM address, then returns the ROM colour together with a drawable flag.
//
// Pipeline: address register -> external ROM (ROM_LAT clocks) -> output register.
// A request issued on cycle 0 produces out_valid on cycle ROM_LAT+2.
// There is no stall path: one request may be accepted every cycle, and
// results come back in request order.
//
// Optional feature: define SPRITE_FETCH_MIRROR_EN to enable horizontal flip.
// When it is defined, mirror=1 addresses column TILE_W-1-x. The range check
// always uses the unflipped x. When it is undefined, mirror is ignored.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   request strobe
//   kind       in   [4:0] tile kind
//   x          in   [5:0] pixel column within the tile
//   y          in   [6:0] pixel row within the tile
//   mirror     in   horizontal flip request
//   rom_addr   out  [ADDR_W-1:0] sprite ROM address (registered)
//   rom_data   in   [CLR_W-1:0] ROM word, valid ROM_LAT clocks after rom_addr
//   out_valid  out  result strobe
//   out_clr    out  [CLR_W-1:0] pixel colour, 0 for out-of-range requests
//   out_opaque out  1 when the pixel is in range and not the key colour
//
// ROM_LAT must be in the range 1..4.

module sprite_fetch #(
  parameter int unsigned       TILE_W  = 48,
  parameter int unsigned       TILE_H  = 70,
  parameter int unsigned       SHEET_W = 1536,
  parameter int unsigned       KINDS   = 32,
  parameter int unsigned       ADDR_W  = 17,
  parameter int unsigned       CLR_W   = 12,
  parameter int unsigned       ROM_LAT = 1,
  parameter logic [CLR_W-1:0]  KEY_CLR = 12'hF0F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [4:0]        kind,
  input  logic [5:0]        x,
  input  logic [6:0]        y,
  input  logic              mirror,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [CLR_W-1:0]  rom_data,
  output logic              out_valid,
  output logic [CLR_W-1:0]  out_clr,
  output logic              out_opaque
);

  logic [31:0]        xe;
  logic               in_range;

  logic [ADDR_W-1:0]  rom_addr_d,   rom_addr_q;
  // Side-band flags travel alongside the ROM access; index ROM_LAT lines up
  // with the rom_data word belonging to the same request.
  logic [ROM_LAT:0]   vld_d,        vld_q;
  logic [ROM_LAT:0]   rng_d,        rng_q;
  logic               out_valid_d,  out_valid_q;
  logic [CLR_W-1:0]   out_clr_d,    out_clr_q;
  logic               out_opaque_d, out_opaque_q;

`ifndef SPRITE_FETCH_MIRROR_EN
  logic unused_mirror;
  assign unused_mirror = mirror;
`endif

  always_comb begin
    xe = {26'd0, x};
`ifdef SPRITE_FETCH_MIRROR_EN
    if (mirror) begin
      // For x >= TILE_W this wraps; the request is out of range anyway and
      // only needs to present some address.
      xe = TILE_W - 32'd1 - {26'd0, x};
    end
`endif
    in_range = ({26'd0, x} < TILE_W) &&
               ({25'd0, y} < TILE_H) &&
               ({27'd0, kind} < KINDS);
  end

  always_comb begin
    rom_addr_d = rom_addr_q;
    if (in_valid) begin
      // Full 32-bit sum, then keep the low ADDR_W bits.
      rom_addr_d = ADDR_W'(SHEET_W * {25'd0, y} + TILE_W * {27'd0, kind} + xe);
    end

    vld_d = {vld_q[ROM_LAT-1:0], in_valid};
    rng_d = {rng_q[ROM_LAT-1:0], in_valid & in_range};

    out_valid_d  = vld_q[ROM_LAT];
    out_clr_d    = out_clr_q;
    out_opaque_d = out_opaque_q;
    if (vld_q[ROM_LAT]) begin
      out_clr_d    = rng_q[ROM_LAT] ? rom_data : '0;
      out_opaque_d = rng_q[ROM_LAT] && (rom_data != KEY_CLR);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_addr_q   <= '0;
      vld_q        <= '0;
      rng_q        <= '0;
      out_valid_q  <= 1'b0;
      out_clr_q    <= '0;
      out_opaque_q <= 1'b0;
    end else begin
      rom_addr_q   <= rom_addr_d;
      vld_q        <= vld_d;
      rng_q        <= rng_d;
      out_valid_q  <= out_valid_d;
      out_clr_q    <= out_clr_d;
      out_opaque_q <= out_opaque_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign out_valid  = out_valid_q;
  assign out_clr    = out_clr_q;
  assign out_opaque = out_opaque_q;

endmodule

// File: tb/tb_sprite_fetch.sv
// Bench for sprite_fetch: three instances share one request stream
//   u0: defaults, u1: KINDS=31, u2: ROM_LAT=3.
// Each has a ROM model returning address[11:0] after its ROM_LAT.
// Expected results are pushed per instance at request time and popped
// when that instance raises out_valid, including the exact arrival cycle.

module tb_sprite_fetch;

  typedef struct {
    logic [11:0] clr;
    logic        opq;
    int          due;
  } sb_t;

`ifdef SPRITE_FETCH_MIRROR_EN
  localparam bit MIR_EN = 1'b1;
`else
  localparam bit MIR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [4:0]  kind;
  logic [5:0]  x;
  logic [6:0]  y;
  logic        mirror;

  logic [16:0] ra [3];
  logic [11:0] rd [3];
  logic        ov [3];
  logic [11:0] oc [3];
  logic        oo [3];
  logic [11:0] p1, p2;

  int          cyc;
  int          n_tests;
  int          n_fail;
  bit          mon_en;
  bit          armed [3];
  logic [11:0] last_clr [3];
  logic        last_opq [3];
  sb_t         sbq [3][$];

  sprite_fetch u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .kind(kind), .x(x), .y(y),
    .mirror(mirror), .rom_addr(ra[0]), .rom_data(rd[0]), .out_valid(ov[0]),
    .out_clr(oc[0]), .out_opaque(oo[0]));

  sprite_fetch #(.KINDS(31)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .kind(kind), .x(x), .y(y),
    .mirror(mirror), .rom_addr(ra[1]), .rom_data(rd[1]), .out_valid(ov[1]),
    .out_clr(oc[1]), .out_opaque(oo[1]));

  sprite_fetch #(.ROM_LAT(3)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .kind(kind), .x(x), .y(y),
    .mirror(mirror), .rom_addr(ra[2]), .rom_data(rd[2]), .out_valid(ov[2]),
    .out_clr(oc[2]), .out_opaque(oo[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    rd[0] <= ra[0][11:0];
    rd[1] <= ra[1][11:0];
    p1    <= ra[2][11:0];
    p2    <= p1;
    rd[2] <= p2;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, obs, obs, exp, exp, cyc);
    end
  endtask

  function automatic int lat_of(int i);
    return (i == 2) ? 3 : 1;
  endfunction

  function automatic int kinds_of(int i);
    return (i == 1) ? 31 : 32;
  endfunction

  function automatic sb_t model(int k, int xx, int yy, bit mir, int kinds, int due);
    sb_t         e;
    int unsigned xe;
    int unsigned a;
    bit          inr;
    xe = xx;
    if (mir && MIR_EN) xe = 47 - xx;
    a = (1536 * yy + 48 * k + xe) & 32'h1FFFF;
    inr = (xx < 48) && (yy < 70) && (k < kinds);
    e.clr = inr ? a[11:0] : 12'h000;
    e.opq = inr && (a[11:0] != 12'hF0F);
    e.due = due;
    return e;
  endfunction

  task automatic req(input int k, input int xx, input int yy, input bit mir);
    @(posedge clk); #1;
    in_valid = 1'b1;
    kind     = 5'(k);
    x        = 6'(xx);
    y        = 7'(yy);
    mirror   = mir;
    for (int i = 0; i < 3; i++)
      sbq[i].push_back(model(k, xx, yy, mir, kinds_of(i), cyc + lat_of(i) + 2));
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic check_zero(input int i, input string tag);
    check_eq({tag, "_rom_addr"},   32'(ra[i]), 32'd0);
    check_eq({tag, "_out_valid"},  32'(ov[i]), 32'd0);
    check_eq({tag, "_out_clr"},    32'(oc[i]), 32'd0);
    check_eq({tag, "_out_opaque"}, 32'(oo[i]), 32'd0);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int i = 0; i < 3; i++) begin
          if (ov[i]) begin
            if (sbq[i].size() == 0) begin
              check_eq($sformatf("u%0d_spurious_valid", i), 32'(ov[i]), 32'd0);
            end else begin
              e = sbq[i].pop_front();
              check_eq($sformatf("u%0d_clr", i),     32'(oc[i]), 32'(e.clr));
              check_eq($sformatf("u%0d_opaque", i),  32'(oo[i]), 32'(e.opq));
              check_eq($sformatf("u%0d_latency", i), 32'(cyc),   32'(e.due));
              last_clr[i] = e.clr;
              last_opq[i] = e.opq;
              armed[i]    = 1'b1;
            end
          end else if (armed[i]) begin
            check_eq($sformatf("u%0d_hold_clr", i), 32'(oc[i]), 32'(last_clr[i]));
            check_eq($sformatf("u%0d_hold_opq", i), 32'(oo[i]), 32'(last_opq[i]));
          end
        end
      end
    end
  end

  initial begin
    int pending;
    cyc = 0; n_tests = 0; n_fail = 0; mon_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      armed[i] = 1'b0; last_clr[i] = '0; last_opq[i] = 1'b0;
    end
    rst_n = 1'b0; in_valid = 1'b0; kind = '0; x = '0; y = '0; mirror = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero(0, "reset");
    check_zero(2, "reset_lat3");
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Address and latency: 1536*3 + 48*2 + 5 = 4709 -> data 0x265.
    req(2, 5, 3, 1'b0);
    idle(1);
    check_eq("addr_4709", 32'(ra[0]), 32'd4709);
    idle(3);
    check_eq("addr_hold", 32'(ra[0]), 32'd4709);
    idle(2);

    // Streaming, back to back.
    for (int i = 0; i < 10; i++) req(0, i, 0, 1'b0);
    idle(6);

    // Range and key.
    req(0, 48, 0, 1'b0);
    req(0, 0, 70, 1'b0);
    req(31, 0, 0, 1'b0);
    req(0, 63, 127, 1'b0);
    req(16, 15, 2, 1'b0);     // 3072 + 768 + 15 = 3855 = 0xF0F
    req(31, 47, 69, 1'b0);
    idle(6);

    // Mirror request.
    req(0, 0, 0, 1'b1);
    idle(1);
    check_eq("addr_mirror", 32'(ra[0]), MIR_EN ? 32'd47 : 32'd0);
    idle(6);

    // Random gapped traffic.
    for (int i = 0; i < 30; i++) begin
      req($urandom_range(31), $urandom_range(63), $urandom_range(127), 1'($urandom_range(1)));
      if ($urandom_range(2) == 0) idle($urandom_range(1, 3));
    end
    idle(8);

    // Reset one cycle after a request; a request offered during reset is ignored.
    req(1, 1, 1, 1'b0);
    @(posedge clk); #1;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    kind = 5'd3; x = 6'd4; y = 7'd5;
    for (int i = 0; i < 3; i++) begin
      sbq[i].delete();
      armed[i] = 1'b0;
    end
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    check_zero(0, "midreset");
    check_zero(2, "midreset_lat3");
    idle(8);

    // Recovery after reset.
    req(4, 7, 9, 1'b0);
    req(5, 8, 10, 1'b0);

    pending = 1;
    for (int t = 0; t < 40 && pending != 0; t++) begin
      idle(1);
      pending = sbq[0].size() + sbq[1].size() + sbq[2].size();
    end
    check_eq("drain_pending", 32'(pending), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
